// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timings and timing helpers for the VGA raster generator.
package vga_pkg;

    localparam int unsigned VGA_HDISP_640  = 640;
    localparam int unsigned VGA_HFP_640    = 16;
    localparam int unsigned VGA_HPULSE_640 = 96;
    localparam int unsigned VGA_HBP_640    = 48;
    localparam int unsigned VGA_VDISP_480  = 480;
    localparam int unsigned VGA_VFP_480    = 11;
    localparam int unsigned VGA_VPULSE_480 = 2;
    localparam int unsigned VGA_VBP_480    = 31;

    typedef enum logic [1:0] {PH_DISP, PH_FP, PH_PULSE, PH_BP} vga_phase_t;

    // Sync/blank bundle carried through the alignment pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_sync_t;

    function automatic int unsigned vga_total(input int unsigned disp, input int unsigned fp,
                                              input int unsigned pulse, input int unsigned bp);
        return disp + fp + pulse + bp;
    endfunction

    // Region of one axis for a counter value; back porch runs to the end of the period
    function automatic vga_phase_t vga_phase(input int unsigned cnt, input int unsigned disp,
                                             input int unsigned fp, input int unsigned pulse);
        if (cnt < disp)
            return PH_DISP;
        if (cnt < disp + fp)
            return PH_FP;
        if (cnt < disp + fp + pulse)
            return PH_PULSE;
        return PH_BP;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request bus from the timing generator to the frame-buffer / pattern source.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int unsigned XW = $clog2(VGA_HDISP_640),
    parameter int unsigned YW = $clog2(VGA_VDISP_480)
);
    logic          REQ;
    logic [XW-1:0] X;
    logic [YW-1:0] Y;
    logic          LINE_START;
    logic          FRAME_START;

    modport master (output REQ, X, Y, LINE_START, FRAME_START);
    modport slave  (input  REQ, X, Y, LINE_START, FRAME_START);
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 is a straight wire.
module vga_delay_line #(
    parameter int unsigned     DEPTH   = 0,
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         VGA_CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_c;
        assign unused_c = ^{VGA_CLK, RST, EN};
        assign q_o      = d_i;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge VGA_CLK) begin
            if (RST) begin
                for (int i = 0; i < int'(DEPTH); i++)
                    stage_q[i] <= RST_VAL;
            end else if (EN) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++)
                    stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel request bus and pipeline-aligned syncs.
// Optional 16-bit frame counter output when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned HDISP  = VGA_HDISP_640,
    parameter int unsigned HFP    = VGA_HFP_640,
    parameter int unsigned HPULSE = VGA_HPULSE_640,
    parameter int unsigned HBP    = VGA_HBP_640,
    parameter int unsigned VDISP  = VGA_VDISP_480,
    parameter int unsigned VFP    = VGA_VFP_480,
    parameter int unsigned VPULSE = VGA_VPULSE_480,
    parameter int unsigned VBP    = VGA_VBP_480,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    parameter int unsigned PIPE   = 0
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    input  logic             EN,
    vga_timing_gen_if.master pix,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK,
    output logic             VGA_SYNC
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      FRAME_CNT
`endif
);

    localparam int unsigned HTOTAL = vga_total(HDISP, HFP, HPULSE, HBP);
    localparam int unsigned VTOTAL = vga_total(VDISP, VFP, VPULSE, VBP);
    localparam int unsigned HCW    = $clog2(HTOTAL);
    localparam int unsigned VCW    = $clog2(VTOTAL);
    localparam int unsigned XW     = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned YW     = (VDISP > 1) ? $clog2(VDISP) : 1;

    localparam vga_sync_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, blank: 1'b0};

    if (HDISP < 1 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
        VDISP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1 || PIPE > 7) begin : g_bad_cfg
        $error("vga_timing_gen: timing parameters must be >= 1 and PIPE <= 7");
    end

    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic           req_q, req_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           ls_q, ls_d;
    logic           fs_q, fs_d;
    vga_sync_t      sync_q, sync_d, sync_dly;
    vga_phase_t     h_ph, v_ph;

    // Raster position: hcnt wraps every line, vcnt advances on that wrap
    always_comb begin
        hcnt_d = hcnt_q + HCW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HCW'(HTOTAL - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == VCW'(VTOTAL - 1))
                vcnt_d = '0;
            else
                vcnt_d = vcnt_q + VCW'(1);
        end
    end

    // Request and sync decode of the current counter position
    always_comb begin
        h_ph = vga_phase(32'(hcnt_q), HDISP, HFP, HPULSE);
        v_ph = vga_phase(32'(vcnt_q), VDISP, VFP, VPULSE);

        req_d = (h_ph == PH_DISP) && (v_ph == PH_DISP);
        x_d   = '0;
        y_d   = '0;
        if (req_d) begin
            x_d = XW'(hcnt_q);
            y_d = YW'(vcnt_q);
        end
        ls_d = req_d && (hcnt_q == '0);
        fs_d = ls_d && (vcnt_q == '0);

        sync_d.hs    = (h_ph == PH_PULSE) ? HS_POL : ~HS_POL;
        sync_d.vs    = (v_ph == PH_PULSE) ? VS_POL : ~VS_POL;
        sync_d.blank = req_d;
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            req_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            sync_q <= SYNC_IDLE;
        end else if (EN) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            req_q  <= req_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            sync_q <= sync_d;
        end
    end

    // Extra stages so syncs line up with pixel data returned PIPE cycles after REQ
    vga_delay_line #(
        .DEPTH   (PIPE),
        .W       ($bits(vga_sync_t)),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .VGA_CLK (VGA_CLK),
        .RST     (RST),
        .EN      (EN),
        .d_i     (sync_q),
        .q_o     (sync_dly)
    );

    assign pix.REQ         = req_q;
    assign pix.X           = x_q;
    assign pix.Y           = y_q;
    assign pix.LINE_START  = ls_q;
    assign pix.FRAME_START = fs_q;

    assign VGA_HS    = sync_dly.hs;
    assign VGA_VS    = sync_dly.vs;
    assign VGA_BLANK = sync_dly.blank;
    assign VGA_SYNC  = 1'b0;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;
    logic        seen_q, seen_d;

    // First frame after reset reports 0; later frame starts count up
    always_comb begin
        fcnt_d = fcnt_q;
        seen_d = seen_q;
        if (fs_d) begin
            seen_d = 1'b1;
            if (seen_q)
                fcnt_d = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            fcnt_q <= '0;
            seen_q <= 1'b0;
        end else if (EN) begin
            fcnt_q <= fcnt_d;
            seen_q <= seen_d;
        end
    end

    assign FRAME_CNT = fcnt_q;
`endif

endmodule
